f1_start_seq: RTL and testbench

- Parametrised successor to the F1 start-light FSM.
- Fills N_LIGHTS lamps one per tick, using an internal tick divider.
- Holds all lamps lit for a pseudo-random number of ticks, then extinguishes them and measures the driver's reaction time in clock cycles.
- Flags a jump start if the driver reacts before lights-out. Sits between the board switch inputs and the LED bar / seven-segment display.

---
 rtl/f1_start_seq.sv | 211 +++++++++++++++++++++
 tb/tb_f1_start_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/f1_start_seq.sv
// -----------------------------------------------------------------------------
// f1_start_seq
//
// F1-style start-light sequencer with reaction timer.
// After a trigger, the lamps fill one per tick, starting with bit 0. All lamps
// then stay lit for a pseudo-random 1..2^HOLD_BITS ticks before going out. The
// block counts clock cycles from lights-out until the driver presses react.
// If react arrives before lights-out, the attempt is flagged as a jump start.
//
// Optional build macro:
//   F1_BLINK_EN - in FAULT the lamp bar toggles all-ones/all-zeros on every
//                 tick, starting all-ones on FAULT entry. When the macro is
//                 undefined, the bar stays dark in FAULT.
//
// Parameters:
//   N_LIGHTS    number of lamps (>= 2)
//   TICK_CYCLES clock cycles per tick (>= 1)
//   HOLD_BITS   width of the random hold sample (1..8)
//   RW          reaction-time counter width
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   trigger      start request (level, sampled each clk)
//   react        driver reaction button (level, sampled each clk)
//   data_out     lamp vector, bit 0 lights first
//   react_time   measured reaction cycles, valid while result_valid=1
//   result_valid high in DONE
//   jump_start   high in FAULT
//   busy         high in ARM, HOLD, GO
//   hold_len     hold length in ticks, latched on HOLD entry
// -----------------------------------------------------------------------------
module f1_start_seq #(
    parameter int N_LIGHTS    = 8,
    parameter int TICK_CYCLES = 48,
    parameter int HOLD_BITS   = 3,
    parameter int RW          = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trigger,
    input  logic                 react,
    output logic [N_LIGHTS-1:0]  data_out,
    output logic [RW-1:0]        react_time,
    output logic                 result_valid,
    output logic                 jump_start,
    output logic                 busy,
    output logic [HOLD_BITS:0]   hold_len
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        HOLD  = 3'd2,
        GO    = 3'd3,
        DONE  = 3'd4,
        FAULT = 3'd5
    } state_t;

    state_t                state_reg, state_next;
    logic [TW-1:0]         tick_cnt_reg, tick_cnt_next;
    logic [7:0]            lfsr_reg, lfsr_next;
    logic [N_LIGHTS-1:0]   lights_reg, lights_next;
    logic [HOLD_BITS:0]    hold_cnt_reg, hold_cnt_next;
    logic [HOLD_BITS:0]    hold_len_reg, hold_len_next;
    logic [RW-1:0]         rcnt_reg, rcnt_next;
    logic [RW-1:0]         react_time_reg, react_time_next;
    logic                  valid_reg, valid_next;
    logic                  jump_reg, jump_next;
    logic                  tick;
    logic [HOLD_BITS:0]    hold_sample;
    logic [N_LIGHTS-1:0]   fault_lights;

    assign tick        = (tick_cnt_reg == TICK_LAST);
    assign hold_sample = {1'b0, lfsr_reg[HOLD_BITS-1:0]} + {{HOLD_BITS{1'b0}}, 1'b1};

`ifdef F1_BLINK_EN
    assign fault_lights = {N_LIGHTS{1'b1}};
`else
    assign fault_lights = {N_LIGHTS{1'b0}};
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        lights_next     = lights_reg;
        hold_cnt_next   = hold_cnt_reg;
        hold_len_next   = hold_len_reg;
        rcnt_next       = rcnt_reg;
        react_time_next = react_time_reg;
        valid_next      = valid_reg;
        jump_next       = jump_reg;

        // x^8 + x^6 + x^5 + x^4 + 1, free-running in every state
        lfsr_next = {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};

        case (state_reg)
            IDLE, DONE, FAULT: begin
                // react is ignored here; trigger alone decides
                if (trigger) begin
                    state_next      = ARM;
                    lights_next     = '0;
                    valid_next      = 1'b0;
                    jump_next       = 1'b0;
                    react_time_next = '0;
                end
`ifdef F1_BLINK_EN
                else if (state_reg == FAULT && tick) begin
                    lights_next = ~lights_reg;
                end
`endif
            end

            ARM: begin
                if (react) begin
                    state_next  = FAULT;
                    jump_next   = 1'b1;
                    lights_next = fault_lights;
                end else if (tick) begin
                    lights_next = {lights_reg[N_LIGHTS-2:0], 1'b1};
                    if (&lights_next) begin
                        state_next    = HOLD;
                        hold_len_next = hold_sample;
                        hold_cnt_next = hold_sample;
                    end
                end
            end

            HOLD: begin
                if (react) begin
                    state_next  = FAULT;
                    jump_next   = 1'b1;
                    lights_next = fault_lights;
                end else if (tick) begin
                    hold_cnt_next = hold_cnt_reg - 1'b1;
                    if (hold_cnt_reg == {{HOLD_BITS{1'b0}}, 1'b1}) begin
                        state_next  = GO;
                        lights_next = '0;
                        rcnt_next   = '0;
                    end
                end
            end

            GO: begin
                if (react) begin
                    state_next      = DONE;
                    react_time_next = rcnt_reg;
                    valid_next      = 1'b1;
                end else if (rcnt_reg != {RW{1'b1}}) begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Divider restarts on ARM entry so the first lamp lands exactly one
        // tick period after the trigger is accepted.
        if (state_reg != ARM && state_next == ARM) begin
            tick_cnt_next = '0;
        end else if (tick) begin
            tick_cnt_next = '0;
        end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            tick_cnt_reg   <= '0;
            lfsr_reg       <= 8'hE1;
            lights_reg     <= '0;
            hold_cnt_reg   <= '0;
            hold_len_reg   <= '0;
            rcnt_reg       <= '0;
            react_time_reg <= '0;
            valid_reg      <= 1'b0;
            jump_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            tick_cnt_reg   <= tick_cnt_next;
            lfsr_reg       <= lfsr_next;
            lights_reg     <= lights_next;
            hold_cnt_reg   <= hold_cnt_next;
            hold_len_reg   <= hold_len_next;
            rcnt_reg       <= rcnt_next;
            react_time_reg <= react_time_next;
            valid_reg      <= valid_next;
            jump_reg       <= jump_next;
        end
    end

    assign data_out     = lights_reg;
    assign react_time   = react_time_reg;
    assign result_valid = valid_reg;
    assign jump_start   = jump_reg;
    assign hold_len     = hold_len_reg;
    assign busy         = (state_reg == ARM) || (state_reg == HOLD) || (state_reg == GO);

endmodule

// File: tb/tb_f1_start_seq.sv
// -----------------------------------------------------------------------------
// tb_f1_start_seq
//
// Self-checking bench for f1_start_seq (N_LIGHTS=4, TICK_CYCLES=4,
// HOLD_BITS=2, RW=4). The expected lamp patterns come from elapsed-cycle
// arithmetic. The expected hold length comes from a free-running model of
// the 8-bit LFSR polynomial. The expected reaction time is min(delay, 15).
// -----------------------------------------------------------------------------
module tb_f1_start_seq;

    localparam int N  = 4;
    localparam int T  = 4;
    localparam int HB = 2;
    localparam int RW = 4;
    localparam int RMAX = (1 << RW) - 1;

    logic          clk;
    logic          rst;
    logic          trigger;
    logic          react;
    logic [N-1:0]  data_out;
    logic [RW-1:0] react_time;
    logic          result_valid;
    logic          jump_start;
    logic          busy;
    logic [HB:0]   hold_len;

    int tests;
    int fails;

    logic [7:0] m_lfsr;
    logic [7:0] m_prev;

    f1_start_seq #(
        .N_LIGHTS   (N),
        .TICK_CYCLES(T),
        .HOLD_BITS  (HB),
        .RW         (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trigger     (trigger),
        .react       (react),
        .data_out    (data_out),
        .react_time  (react_time),
        .result_valid(result_valid),
        .jump_start  (jump_start),
        .busy        (busy),
        .hold_len    (hold_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial x^8+x^6+x^5+x^4+1: new bit = parity of bits 7,5,4,3
    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], ^(v & 8'hB8)};
    endfunction

    // Reference LFSR; m_prev holds the value the DUT saw at the latest edge
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr <= 8'hE1;
            m_prev <= 8'hE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    function automatic logic [N-1:0] ones(input int k);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i < k) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_fault(input string tag);
        trigger = 1'b0;
        check({tag, "_jump"},  32'(jump_start),   32'd1);
        check({tag, "_valid"}, 32'(result_valid), 32'd0);
        check({tag, "_busy"},  32'(busy),         32'd0);
`ifdef F1_BLINK_EN
        check({tag, "_lamps"}, 32'(data_out), 32'(ones(N)));
`else
        check({tag, "_lamps"}, 32'(data_out), 32'd0);
`endif
        for (int c = 0; c < 2 * T; c++) begin
            react = 1'($urandom_range(0, 1));
            step(1);
`ifdef F1_BLINK_EN
            check({tag, "_blink"}, 32'((data_out == '0) || (&data_out)), 32'd1);
`else
            check({tag, "_dark"}, 32'(data_out), 32'd0);
`endif
            check({tag, "_hold_jump"}, 32'(jump_start), 32'd1);
        end
        react = 1'b0;
        $display("[TB] txn jump start at %0s", tag);
    endtask

    // kind 0: normal run with reaction delay d
    // kind 1: react asserted on edge d after ARM entry (jump start)
    // kind 2: asynchronous reset in the middle of HOLD
    task automatic run_txn(input int kind, input int d, input bit trig_react);
        int exp_hold;
        int exp_rt;
        trigger = 1'b1;
        react   = trig_react;
        step(1);
        trigger = 1'b0;
        react   = 1'b0;
        check("arm_busy",  32'(busy),         32'd1);
        check("arm_lamps", 32'(data_out),     32'd0);
        check("arm_jump",  32'(jump_start),   32'd0);
        check("arm_valid", 32'(result_valid), 32'd0);

        for (int c = 1; c <= N * T; c++) begin
            if (kind == 1 && c == d) begin
                trigger = 1'b0;
                react   = 1'b1;
                step(1);
                check_fault("arm");
                return;
            end
            step(1);
            trigger = 1'($urandom_range(0, 1));
            check("fill_lamps", 32'(data_out), 32'(ones(c / T)));
            check("fill_busy",  32'(busy),     32'd1);
        end

        exp_hold = int'(m_prev[HB-1:0]) + 1;
        check("hold_len", 32'(hold_len), 32'(exp_hold));

        for (int c = 1; c <= exp_hold * T; c++) begin
            if (kind == 1 && N * T + c == d) begin
                trigger = 1'b0;
                react   = 1'b1;
                step(1);
                check_fault("hold");
                return;
            end
            if (kind == 2 && c == 2) begin
                trigger = 1'b0;
                #2;
                rst = 1'b0;
                #1;
                check("rst_lamps", 32'(data_out),     32'd0);
                check("rst_busy",  32'(busy),         32'd0);
                check("rst_valid", 32'(result_valid), 32'd0);
                check("rst_jump",  32'(jump_start),   32'd0);
                check("rst_hold",  32'(hold_len),     32'd0);
                check("rst_rt",    32'(react_time),   32'd0);
                @(posedge clk);
                #1;
                check("rst_held_busy", 32'(busy), 32'd0);
                rst = 1'b1;
                step(1);
                $display("[TB] txn async reset during HOLD");
                return;
            end
            step(1);
            trigger = 1'($urandom_range(0, 1));
            check("hold_lamps", 32'(data_out), (c == exp_hold * T) ? 32'd0 : 32'(ones(N)));
            check("hold_busy",  32'(busy),     32'd1);
        end

        for (int c = 0; c < d; c++) begin
            step(1);
            trigger = 1'($urandom_range(0, 1));
            check("go_busy",  32'(busy),         32'd1);
            check("go_valid", 32'(result_valid), 32'd0);
        end
        trigger = 1'b0;
        react   = 1'b1;
        step(1);
        react   = 1'b0;
        exp_rt  = (d > RMAX) ? RMAX : d;
        check("done_rt",    32'(react_time),   32'(exp_rt));
        check("done_valid", 32'(result_valid), 32'd1);
        check("done_busy",  32'(busy),         32'd0);
        check("done_jump",  32'(jump_start),   32'd0);
        check("done_lamps", 32'(data_out),     32'd0);
        for (int c = 0; c < 3; c++) begin
            react = 1'($urandom_range(0, 1));
            step(1);
            check("done_hold_rt",    32'(react_time),   32'(exp_rt));
            check("done_hold_valid", 32'(result_valid), 32'd1);
        end
        react = 1'b0;
        $display("[TB] txn hold=%0d delay=%0d react_time=%0d expected=%0d",
                 exp_hold, d, react_time, exp_rt);
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        trigger = 1'b0;
        react   = 1'b0;
        rst     = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        check("reset_lamps", 32'(data_out),     32'd0);
        check("reset_busy",  32'(busy),         32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_jump",  32'(jump_start),   32'd0);
        check("reset_hold",  32'(hold_len),     32'd0);
        check("reset_rt",    32'(react_time),   32'd0);
        step(2);
        rst = 1'b1;
        step(1);

        run_txn(0, 10, 1'b0);          // reaction 10 cycles after lights-out
        run_txn(0, 0, 1'b0);           // react in first GO cycle
        run_txn(1, 6, 1'b0);           // jump start during fill
        run_txn(1, N * T + 2, 1'b1);   // jump start during hold, from FAULT
        run_txn(0, 20, 1'b0);          // counter saturation
        run_txn(2, 0, 1'b0);           // async reset in HOLD
        run_txn(0, 7, 1'b1);           // trigger+react in IDLE -> ARM, no fault

        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                run_txn(0, int'($urandom_range(0, 18)), 1'($urandom_range(0, 1)));
            end else begin
                run_txn(1, int'($urandom_range(1, N * T + T)), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
